// File: rtl/sys_ctrl_pkg.sv
// Shared constants and FSM state encoding for the command frame decoder.
package sys_ctrl_pkg;

  localparam logic [7:0] RF_WR   = 8'hAA;
  localparam logic [7:0] RF_RD   = 8'hBB;
  localparam logic [7:0] ALU_OP  = 8'hCC;
  localparam logic [7:0] ALU_NOP = 8'hDD;

  localparam int REG0_ADDR = 0;
  localparam int REG1_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OP_A,
    OP_B,
    OP_FUN,
    ALU_WAIT,
    PUSH_RD,
    PUSH_LSB,
    PUSH_MSB
  } state_t;

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Bundle of RX, register-file, ALU and TX FIFO signals around the command decoder.
interface cmd_frame_decoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);

  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RF_RD_DATA;
  logic                    RF_RD_VALID;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VALID;
  logic                    FIFO_FULL;
  logic [ADDR_WIDTH-1:0]   RF_ADDR;
  logic                    RF_WR_EN;
  logic                    RF_RD_EN;
  logic [DATA_WIDTH-1:0]   RF_WR_DATA;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    CMD_ERR;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    output RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    input  RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, ALU_EN, ALU_FUN, CLK_EN,
           TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface

// File: rtl/cmd_frame_decoder.sv
// Parses RX command frames into register-file / ALU control and queues response bytes for TX.
module cmd_frame_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input logic CLK,
  input logic RST_N,
  cmd_frame_decoder_if.master bus
);

  state_t                  state_p0, state_p1;
  logic [ADDR_WIDTH-1:0]   wr_addr_p0, wr_addr_p1;
  logic [DATA_WIDTH-1:0]   rd_data_p0, rd_data_p1;
  logic [2*DATA_WIDTH-1:0] alu_res_p0, alu_res_p1;
  logic [ADDR_WIDTH-1:0]   rf_addr_p0, rf_addr_p1;
  logic [DATA_WIDTH-1:0]   rf_wr_data_p0, rf_wr_data_p1;
  logic                    rf_wr_en_p0, rf_wr_en_p1;
  logic                    rf_rd_en_p0, rf_rd_en_p1;
  logic                    alu_en_p0, alu_en_p1;
  logic [FUN_WIDTH-1:0]    alu_fun_p0, alu_fun_p1;
  logic [DATA_WIDTH-1:0]   tx_data_p0, tx_data_p1;
  logic                    tx_vld_p0, tx_vld_p1;
  logic                    cmd_err_p0, cmd_err_p1;

  logic [ADDR_WIDTH-1:0]   rx_addr;
  logic [FUN_WIDTH-1:0]    rx_fun;

  assign rx_addr = bus.RX_P_DATA[ADDR_WIDTH-1:0];
  assign rx_fun  = bus.RX_P_DATA[FUN_WIDTH-1:0];

  function automatic logic is_cmd(input logic [DATA_WIDTH-1:0] b);
    return (b == DATA_WIDTH'(RF_WR))  || (b == DATA_WIDTH'(RF_RD)) ||
           (b == DATA_WIDTH'(ALU_OP)) || (b == DATA_WIDTH'(ALU_NOP));
  endfunction

  always_comb begin
    state_p0 = state_p1;
    case (state_p1)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == DATA_WIDTH'(RF_WR))        state_p0 = WR_ADDR;
          else if (bus.RX_P_DATA == DATA_WIDTH'(RF_RD))   state_p0 = RD_ADDR;
          else if (bus.RX_P_DATA == DATA_WIDTH'(ALU_OP))  state_p0 = OP_A;
          else if (bus.RX_P_DATA == DATA_WIDTH'(ALU_NOP)) state_p0 = OP_FUN;
        end
      end
      WR_ADDR:  if (bus.RX_D_VLD)      state_p0 = WR_DATA;
      WR_DATA:  if (bus.RX_D_VLD)      state_p0 = IDLE;
      RD_ADDR:  if (bus.RX_D_VLD)      state_p0 = RD_WAIT;
      RD_WAIT:  if (bus.RF_RD_VALID)   state_p0 = PUSH_RD;
      OP_A:     if (bus.RX_D_VLD)      state_p0 = OP_B;
      OP_B:     if (bus.RX_D_VLD)      state_p0 = OP_FUN;
      OP_FUN:   if (bus.RX_D_VLD)      state_p0 = ALU_WAIT;
      ALU_WAIT: if (bus.ALU_OUT_VALID) state_p0 = PUSH_LSB;
      PUSH_RD:  if (!bus.FIFO_FULL)    state_p0 = IDLE;
      PUSH_LSB: if (!bus.FIFO_FULL)    state_p0 = PUSH_MSB;
      PUSH_MSB: if (!bus.FIFO_FULL)    state_p0 = IDLE;
      default:                         state_p0 = IDLE;
    endcase
  end

  // Busy states drop any incoming byte and flag it; mid-frame command values are plain data.
  always_comb begin
    wr_addr_p0    = wr_addr_p1;
    rd_data_p0    = rd_data_p1;
    alu_res_p0    = alu_res_p1;
    rf_addr_p0    = rf_addr_p1;
    rf_wr_data_p0 = rf_wr_data_p1;
    alu_fun_p0    = alu_fun_p1;
    tx_data_p0    = tx_data_p1;
    rf_wr_en_p0   = 1'b0;
    rf_rd_en_p0   = 1'b0;
    tx_vld_p0     = 1'b0;
    cmd_err_p0    = 1'b0;
    alu_en_p0     = (state_p0 == ALU_WAIT);
    case (state_p1)
      IDLE: cmd_err_p0 = bus.RX_D_VLD && !is_cmd(bus.RX_P_DATA);
      WR_ADDR: if (bus.RX_D_VLD) wr_addr_p0 = rx_addr;
      WR_DATA: if (bus.RX_D_VLD) begin
        rf_wr_en_p0   = 1'b1;
        rf_addr_p0    = wr_addr_p1;
        rf_wr_data_p0 = bus.RX_P_DATA;
      end
      RD_ADDR: if (bus.RX_D_VLD) begin
        rf_rd_en_p0 = 1'b1;
        rf_addr_p0  = rx_addr;
      end
      RD_WAIT: begin
        cmd_err_p0 = bus.RX_D_VLD;
        if (bus.RF_RD_VALID) rd_data_p0 = bus.RF_RD_DATA;
      end
      OP_A: if (bus.RX_D_VLD) begin
        rf_wr_en_p0   = 1'b1;
        rf_addr_p0    = ADDR_WIDTH'(REG0_ADDR);
        rf_wr_data_p0 = bus.RX_P_DATA;
      end
      OP_B: if (bus.RX_D_VLD) begin
        rf_wr_en_p0   = 1'b1;
        rf_addr_p0    = ADDR_WIDTH'(REG1_ADDR);
        rf_wr_data_p0 = bus.RX_P_DATA;
      end
      OP_FUN: if (bus.RX_D_VLD) alu_fun_p0 = rx_fun;
      ALU_WAIT: begin
        cmd_err_p0 = bus.RX_D_VLD;
        if (bus.ALU_OUT_VALID) alu_res_p0 = bus.ALU_OUT;
      end
      PUSH_RD: begin
        cmd_err_p0 = bus.RX_D_VLD;
        if (!bus.FIFO_FULL) begin
          tx_vld_p0  = 1'b1;
          tx_data_p0 = rd_data_p1;
        end
      end
      PUSH_LSB: begin
        cmd_err_p0 = bus.RX_D_VLD;
        if (!bus.FIFO_FULL) begin
          tx_vld_p0  = 1'b1;
          tx_data_p0 = alu_res_p1[DATA_WIDTH-1:0];
        end
      end
      PUSH_MSB: begin
        cmd_err_p0 = bus.RX_D_VLD;
        if (!bus.FIFO_FULL) begin
          tx_vld_p0  = 1'b1;
          tx_data_p0 = alu_res_p1[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

  // p0 -> p1: every output and latched operand is registered and cleared by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_p1      <= IDLE;
      wr_addr_p1    <= '0;
      rd_data_p1    <= '0;
      alu_res_p1    <= '0;
      rf_addr_p1    <= '0;
      rf_wr_data_p1 <= '0;
      rf_wr_en_p1   <= 1'b0;
      rf_rd_en_p1   <= 1'b0;
      alu_en_p1     <= 1'b0;
      alu_fun_p1    <= '0;
      tx_data_p1    <= '0;
      tx_vld_p1     <= 1'b0;
      cmd_err_p1    <= 1'b0;
    end else begin
      state_p1      <= state_p0;
      wr_addr_p1    <= wr_addr_p0;
      rd_data_p1    <= rd_data_p0;
      alu_res_p1    <= alu_res_p0;
      rf_addr_p1    <= rf_addr_p0;
      rf_wr_data_p1 <= rf_wr_data_p0;
      rf_wr_en_p1   <= rf_wr_en_p0;
      rf_rd_en_p1   <= rf_rd_en_p0;
      alu_en_p1     <= alu_en_p0;
      alu_fun_p1    <= alu_fun_p0;
      tx_data_p1    <= tx_data_p0;
      tx_vld_p1     <= tx_vld_p0;
      cmd_err_p1    <= cmd_err_p0;
    end
  end

  assign bus.RF_ADDR    = rf_addr_p1;
  assign bus.RF_WR_EN   = rf_wr_en_p1;
  assign bus.RF_RD_EN   = rf_rd_en_p1;
  assign bus.RF_WR_DATA = rf_wr_data_p1;
  assign bus.ALU_EN     = alu_en_p1;
  assign bus.CLK_EN     = alu_en_p1;
  assign bus.ALU_FUN    = alu_fun_p1;
  assign bus.TX_P_DATA  = tx_data_p1;
  assign bus.TX_D_VLD   = tx_vld_p1;
  assign bus.CMD_ERR    = cmd_err_p1;

endmodule
